// File: rtl/button_debouncer.sv
// Debouncer for raw board push-buttons: a 2-flop synchroniser, polarity normalisation, and per-channel stability counting.
// Define BUTTON_DEBOUNCER_REPEAT_EN to add press auto-repeat while a button is held.
module button_debouncer #(
   parameter int WIDTH           = 4,
   parameter int ACTIVE_LOW_IN   = 1,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] btn_raw,
   output logic [WIDTH-1:0] btn_clean,
   output logic [WIDTH-1:0] btn_press,
   output logic [WIDTH-1:0] btn_release
);

   localparam logic [WIDTH-1:0] IDLE_PINS = (ACTIVE_LOW_IN != 0) ? '1 : '0;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > ((64'(1) << CNT_W) - 64'(1)) ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("button_debouncer: illegal DEBOUNCE_CYCLES/CNT_W/REPEAT_* combination");
   end

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] w_lvl;

   // Reset to the idle pin level so a released button never looks pressed right after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= IDLE_PINS;
         r_s2 <= IDLE_PINS;
      end else begin
         r_s1 <= btn_raw;
         r_s2 <= r_s1;
      end
   end

   assign w_lvl = (ACTIVE_LOW_IN != 0) ? ~r_s2 : r_s2;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             r_clean;
      logic             r_press;
      logic             r_release;
      logic             w_accept;
      logic             w_rep_fire;

      assign w_accept = (w_lvl[gi] != r_clean) && (r_cnt == CNT_LAST);

      always_ff @(posedge clk) begin
         if (reset) begin
            r_cnt     <= '0;
            r_clean   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_press   <= (w_accept & w_lvl[gi]) | w_rep_fire;
            r_release <= w_accept & ~w_lvl[gi];
            if (w_lvl[gi] == r_clean) begin
               r_cnt <= '0;
            end else if (w_accept) begin
               r_clean <= w_lvl[gi];
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int REP_W   = $clog2(REP_MAX + 1);

      logic [REP_W-1:0] r_rep;
      logic             r_armed;

      // First target is the initial delay; once it has fired, the period applies.
      assign w_rep_fire = r_clean && !w_accept &&
                          (r_rep == (r_armed ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1)));

      always_ff @(posedge clk) begin
         if (reset || !r_clean || w_accept) begin
            r_rep   <= '0;
            r_armed <= 1'b0;
         end else if (w_rep_fire) begin
            r_rep   <= '0;
            r_armed <= 1'b1;
         end else begin
            r_rep <= r_rep + REP_W'(1);
         end
      end
`else
      assign w_rep_fire = 1'b0;
`endif

      assign btn_clean[gi]   = r_clean;
      assign btn_press[gi]   = r_press;
      assign btn_release[gi] = r_release;
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed test-plan steps plus random bouncing,
// compared every cycle against a window-based behavioural model.
module tb_button_debouncer;
   localparam int W  = 4;
   localparam int DC = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] btn_raw = 4'hF;
   logic [W-1:0] btn_clean, btn_press, btn_release;

   int n_cmp = 0;
   int n_bad = 0;

   button_debouncer #(
      .WIDTH(W), .ACTIVE_LOW_IN(1), .DEBOUNCE_CYCLES(DC), .CNT_W(16),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw),
      .btn_clean(btn_clean), .btn_press(btn_press), .btn_release(btn_release)
   );

   always #5 clk = ~clk;

   // Model: pins reach the level logic two edges late; a level is accepted once the
   // last DC observed levels since the previous acceptance all differ from it.
   logic [W-1:0]  m_s1 = 4'hF, m_s2 = 4'hF;
   logic [W-1:0]  m_clean = '0, m_press = '0, m_rel = '0;
   logic [DC-1:0] m_win [W];
   int            m_fill [W];
   int            m_held [W];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [W-1:0] raw, input logic rst);
      logic [W-1:0] lvl;
      m_press = '0;
      m_rel   = '0;
      if (rst) begin
         m_s1 = 4'hF; m_s2 = 4'hF; m_clean = '0;
         for (int c = 0; c < W; c++) begin m_fill[c] = 0; m_held[c] = 0; m_win[c] = '0; end
         return;
      end
      lvl  = ~m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      for (int c = 0; c < W; c++) begin
         m_win[c] = {m_win[c][DC-2:0], lvl[c]};
         if (m_fill[c] < DC) m_fill[c]++;
         if (m_fill[c] == DC && m_win[c] == {DC{~m_clean[c]}}) begin
            m_clean[c] = ~m_clean[c];
            if (m_clean[c]) m_press[c] = 1'b1; else m_rel[c] = 1'b1;
            m_fill[c] = 0;
            m_held[c] = 0;
         end else if (m_clean[c]) begin
            m_held[c]++;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
            if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RP == 0))
               m_press[c] = 1'b1;
`endif
         end
      end
   endtask

   task automatic cycle(input logic [W-1:0] raw, input logic rst);
      btn_raw = raw;
      reset   = rst;
      @(posedge clk);
      model_edge(raw, rst);
      #1;
      chk("clean", 32'(btn_clean), 32'(m_clean));
      chk("press", 32'(btn_press), 32'(m_press));
      chk("release", 32'(btn_release), 32'(m_rel));
      chk("press_and_release", 32'(btn_press & btn_release), 32'd0);
      $display("t=%0t rst=%b raw=%h clean=%h press=%h release=%h", $time, rst, raw, btn_clean, btn_press, btn_release);
   endtask

   initial begin : stim
      int first, presses, nbits;
      logic [W-1:0] raw;
      int exp_off [5] = '{0, 20, 28, 36, 44};
      int offs [$];

      for (int c = 0; c < W; c++) begin m_win[c] = '0; m_fill[c] = 0; m_held[c] = 0; end

      // Reset held with all pins idle, then idle run.
      for (int i = 0; i < 10; i++) cycle(4'hF, 1'b1);
      for (int i = 0; i < 10; i++) cycle(4'hF, 1'b0);
      chk("idle_clean", 32'(btn_clean), 32'd0);

      // Clean single press on channel 0: accepted 5 edges after first sample.
      first = -1; presses = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(4'hE, 1'b0);
         if (btn_clean[0] && first < 0) first = i;
         if (btn_press[0]) presses++;
      end
      chk("ch0_latency", 32'(first), 32'd5);
      chk("ch0_press_count", 32'(presses), 32'd1);

      // Bouncing channel 1: toggles every 2 cycles, then held low.
      presses = 0;
      for (int i = 0; i < 12; i++) begin
         raw = 4'hE;
         raw[1] = ((i / 2) % 2) != 0;
         cycle(raw, 1'b0);
         if (btn_press[1]) presses++;
      end
      chk("ch1_no_change_in_bounce", 32'(btn_clean[1]), 32'd0);
      first = -1;
      for (int i = 0; i < 12; i++) begin
         cycle(4'hC, 1'b0);
         if (btn_clean[1] && first < 0) first = i;
         if (btn_press[1]) presses++;
      end
      chk("ch1_latency", 32'(first), 32'd5);
      chk("ch1_press_count", 32'(presses), 32'd1);

      // Simultaneous press on channels 2 and 3, then release of channel 2 only.
      for (int i = 0; i < 10; i++) cycle(4'hF, 1'b0);
      first = -1;
      for (int i = 0; i < 10; i++) begin
         cycle(4'h3, 1'b0);
         if (btn_press != 0 && first < 0) begin first = i; chk("ch23_press", 32'(btn_press), 32'hC); end
      end
      chk("ch23_press_seen", 32'(first), 32'd5);
      first = -1;
      for (int i = 0; i < 10; i++) begin
         cycle(4'h7, 1'b0);
         if (btn_release != 0 && first < 0) begin
            first = i;
            chk("ch2_release", 32'(btn_release), 32'h4);
            chk("ch2_release_clean", 32'(btn_clean), 32'h8);
         end
      end
      chk("ch2_release_seen", 32'(first), 32'd5);

      // Channel 0 held through a one-cycle reset: re-accepted as a new press.
      for (int i = 0; i < 10; i++) cycle(4'hF, 1'b0);
      for (int i = 0; i < 8; i++) cycle(4'hE, 1'b0);
      chk("ch0_held_before_reset", 32'(btn_clean), 32'h1);
      cycle(4'hE, 1'b1);
      chk("reset_clears_clean", 32'(btn_clean), 32'd0);
      chk("reset_no_release", 32'(btn_release), 32'd0);
      first = -1;
      for (int i = 0; i < 10; i++) begin
         cycle(4'hE, 1'b0);
         if (btn_press[0] && first < 0) first = i;
      end
      chk("post_reset_press", 32'(first), 32'd5);

      // Long hold on channel 0 for the auto-repeat behaviour.
      for (int i = 0; i < 10; i++) cycle(4'hF, 1'b0);
      first = -1;
      for (int i = 0; i < 10 && first < 0; i++) begin
         cycle(4'hE, 1'b0);
         if (btn_press[0]) first = i;
      end
      chk("hold_accept_seen", 32'(first >= 0), 32'd1);
      offs.push_back(0);
      for (int i = 1; i <= 50; i++) begin
         cycle(4'hE, 1'b0);
         if (btn_press[0]) offs.push_back(i);
      end
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      nbits = 5;
`else
      nbits = 1;
`endif
      chk("repeat_count", 32'(offs.size()), 32'(nbits));
      for (int k = 0; k < nbits && k < offs.size(); k++) chk("repeat_offset", 32'(offs[k]), 32'(exp_off[k]));
      presses = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(4'hF, 1'b0);
         if (btn_press[0]) presses++;
      end
      chk("no_press_after_release", 32'(presses), 32'd0);

      // Random bouncing with occasional reset.
      raw = 4'hF;
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < W; c++)
            if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
         cycle(raw, $urandom_range(0, 199) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
